// File: rtl/event_window_gen.sv
// Baseline-corrected event framer: emits each threshold event as one contiguous Data_Out_Valid burst.
// Optional BASELINE_TRACK_EN builds an IIR baseline tracker; otherwise the Baseline port is registered.
module event_window_gen #(
  parameter int PRE_LEN    = 8,
  parameter int POST_LEN   = 16,
  parameter int MAX_LEN    = 1024,
  parameter int MIN_GAP    = 8,
  parameter int BASE_SHIFT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic signed [15:0] i_ADC_Data,
  input  logic               i_ADC_Valid,
  input  logic               i_Enable,
  input  logic [15:0]        i_Threshold,
  input  logic signed [15:0] i_Baseline,
  input  logic               i_Clear,
  output logic signed [15:0] o_Data_Out,
  output logic               o_Data_Out_Valid,
  output logic [15:0]        o_Event_Count,
  output logic               o_Truncated,
  output logic               o_Gap_Err,
  output logic signed [15:0] o_Baseline_Out,
  output logic               o_Busy
);

  typedef enum logic [2:0] {IDLE, FILL, ARMED, ACTIVE, TAIL, HOLDOFF} state_t;
  localparam int CNT_W = 16;

  state_t             r_st, w_stNext;
  logic [CNT_W-1:0]   r_cnt, w_cntNext, r_len, w_lenNext, w_lenInc;
  logic signed [15:0] w_base, r_corr, r_dout;
  logic signed [15:0] r_dly [PRE_LEN];
  logic signed [16:0] w_diffC;
  logic signed [15:0] w_sat;
  logic [16:0]        w_abs;
  logic               r_corrValid, w_trig, w_trackEn, w_gap;
  logic               r_valid, w_validNext, w_endWin, w_setTrunc, w_setGap;
  logic               r_trunc, r_gapErr;
  logic [15:0]        r_evtCnt;

  assign w_trackEn = i_ADC_Valid && (r_st == IDLE || r_st == FILL || r_st == ARMED);

`ifdef BASELINE_TRACK_EN
  localparam int ACC_W = 16 + BASE_SHIFT;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W:0]   w_adcExt, w_accDiff, w_accStep;

  assign w_adcExt  = (ACC_W+1)'(i_ADC_Data) <<< BASE_SHIFT;
  assign w_accDiff = w_adcExt - (ACC_W+1)'(r_acc);
  assign w_accStep = w_accDiff >>> BASE_SHIFT;
  assign w_base    = r_acc[ACC_W-1:BASE_SHIFT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_acc <= '0;
    else if (w_trackEn) r_acc <= r_acc + ACC_W'(w_accStep);
  end
`else
  logic signed [15:0] r_base;
  assign w_base = r_base;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_base <= '0;
    else if (w_trackEn) r_base <= i_Baseline;
  end
`endif

  // Corrected sample saturates to 16 bits; its magnitude is kept at 17 bits so |-32768| is exact.
  assign w_diffC = 17'(i_ADC_Data) - 17'(w_base);
  assign w_sat   = (w_diffC[16] != w_diffC[15]) ? (w_diffC[16] ? 16'sh8000 : 16'sh7FFF)
                                                 : w_diffC[15:0];
  assign w_abs   = r_corr[15] ? 17'(-(17'(r_corr))) : 17'(r_corr);
  assign w_trig  = r_corrValid && (w_abs > {1'b0, i_Threshold});
  assign w_gap   = !i_ADC_Valid || !r_corrValid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_corr      <= '0;
      r_corrValid <= 1'b0;
      r_dout      <= '0;
      for (int i = 0; i < PRE_LEN; i++) r_dly[i] <= '0;
    end else begin
      r_corr      <= w_sat;
      r_corrValid <= i_ADC_Valid;
      r_dout      <= r_dly[PRE_LEN-1];
      if (r_corrValid) begin
        r_dly[0] <= r_corr;
        for (int i = 1; i < PRE_LEN; i++) r_dly[i] <= r_dly[i-1];
      end
    end
  end

  // The tail runs PRE_LEN+POST_LEN samples past the last trigger because the output lags the trigger by PRE_LEN.
  assign w_lenInc = r_len + 1'b1;

  always_comb begin
    w_stNext    = r_st;
    w_cntNext   = r_cnt;
    w_lenNext   = r_len;
    w_validNext = 1'b0;
    w_endWin    = 1'b0;
    w_setTrunc  = 1'b0;
    w_setGap    = 1'b0;
    case (r_st)
      IDLE: begin
        if (i_Enable) begin
          w_stNext  = FILL;
          w_cntNext = '0;
        end
      end
      FILL: begin
        if (!i_Enable) w_stNext = IDLE;
        else if (r_corrValid) begin
          if (r_cnt == CNT_W'(PRE_LEN - 1)) begin
            w_stNext  = ARMED;
            w_cntNext = '0;
          end else w_cntNext = r_cnt + 1'b1;
        end
      end
      ARMED: begin
        if (!i_Enable) w_stNext = IDLE;
        else if (w_trig) begin
          w_stNext    = ACTIVE;
          w_validNext = 1'b1;
          w_lenNext   = CNT_W'(1);
        end
      end
      ACTIVE, TAIL: begin
        if (w_gap) begin
          w_stNext  = HOLDOFF;
          w_cntNext = '0;
          w_endWin  = 1'b1;
          w_setGap  = 1'b1;
        end else begin
          w_validNext = 1'b1;
          w_lenNext   = w_lenInc;
          if (w_trig) w_stNext = ACTIVE;
          else if (r_st == ACTIVE) begin
            w_stNext  = TAIL;
            w_cntNext = CNT_W'(1);
          end else begin
            w_cntNext = r_cnt + 1'b1;
            if (w_cntNext == CNT_W'(PRE_LEN + POST_LEN)) begin
              w_stNext  = HOLDOFF;
              w_cntNext = '0;
              w_endWin  = 1'b1;
            end
          end
          if (w_lenInc == CNT_W'(MAX_LEN)) begin
            w_stNext   = HOLDOFF;
            w_cntNext  = '0;
            w_endWin   = 1'b1;
            w_setTrunc = 1'b1;
          end
        end
      end
      HOLDOFF: begin
        if (r_cnt == CNT_W'(MIN_GAP - 1)) begin
          w_stNext  = i_Enable ? FILL : IDLE;
          w_cntNext = '0;
        end else w_cntNext = r_cnt + 1'b1;
      end
      default: w_stNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st     <= IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_valid  <= 1'b0;
      r_evtCnt <= '0;
      r_trunc  <= 1'b0;
      r_gapErr <= 1'b0;
    end else begin
      r_st    <= w_stNext;
      r_cnt   <= w_cntNext;
      r_len   <= w_lenNext;
      r_valid <= w_validNext;
      if (w_endWin) r_evtCnt <= r_evtCnt + 16'd1;
      if (w_setTrunc)   r_trunc <= 1'b1;
      else if (i_Clear) r_trunc <= 1'b0;
      if (w_setGap)     r_gapErr <= 1'b1;
      else if (i_Clear) r_gapErr <= 1'b0;
    end
  end

  assign o_Data_Out       = r_dout;
  assign o_Data_Out_Valid = r_valid;
  assign o_Event_Count    = r_evtCnt;
  assign o_Truncated      = r_trunc;
  assign o_Gap_Err        = r_gapErr;
  assign o_Baseline_Out   = w_base;
  assign o_Busy           = (r_st == ACTIVE) || (r_st == TAIL) || (r_st == HOLDOFF);

endmodule

// File: tb/tb_event_window_gen.sv
// Directed bench for event_window_gen: one task per scenario, expectations worked out by hand.
// A second instance with MAX_LEN=32 covers truncation.
module tb_event_window_gen;
  localparam int PRE = 8, GAP = 8, NMAX = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, adcValid, enable, clear;
  logic signed [15:0] adcData, baseline;
  logic [15:0] threshold;
  logic signed [15:0] dOut, dBase, tOut, tBase;
  logic dValid, dTrunc, dGap, dBusy, tValid, tTrunc, tGap, tBusy;
  logic [15:0] dCount, tCount;

  int nVec = 0, nErr = 0;
  logic signed [15:0] stim [NMAX];
  logic stimV [NMAX];
  logic obsV [NMAX];
  logic obsVT [NMAX];
  logic signed [15:0] obsD [NMAX];
  int runStart [8];
  int runLen [8];
  int runCount;

  event_window_gen #(.PRE_LEN(8), .POST_LEN(16), .MAX_LEN(1024), .MIN_GAP(8), .BASE_SHIFT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ADC_Data(adcData), .i_ADC_Valid(adcValid), .i_Enable(enable),
    .i_Threshold(threshold), .i_Baseline(baseline), .i_Clear(clear),
    .o_Data_Out(dOut), .o_Data_Out_Valid(dValid), .o_Event_Count(dCount), .o_Truncated(dTrunc),
    .o_Gap_Err(dGap), .o_Baseline_Out(dBase), .o_Busy(dBusy));

  event_window_gen #(.PRE_LEN(8), .POST_LEN(16), .MAX_LEN(32), .MIN_GAP(8), .BASE_SHIFT(4)) dutT (
    .i_clk(clk), .i_rst_n(rst_n), .i_ADC_Data(adcData), .i_ADC_Valid(adcValid), .i_Enable(enable),
    .i_Threshold(threshold), .i_Baseline(baseline), .i_Clear(clear),
    .o_Data_Out(tOut), .o_Data_Out_Valid(tValid), .o_Event_Count(tCount), .o_Truncated(tTrunc),
    .o_Gap_Err(tGap), .o_Baseline_Out(tBase), .o_Busy(tBusy));

  task automatic doReset();
    rst_n = 1'b0; adcData = '0; adcValid = 1'b1; enable = 1'b0;
    threshold = 16'd100; baseline = '0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic loadStim(input logic signed [15:0] v);
    for (int i = 0; i < NMAX; i++) begin stim[i] = v; stimV[i] = 1'b1; end
  endtask

  // Iteration i drives sample i, then records what the DUTs show just after that edge.
  task automatic runStream(input int n);
    for (int i = 0; i < n; i++) begin
      adcData = stim[i]; adcValid = stimV[i];
      @(posedge clk); #1;
      obsV[i] = dValid; obsVT[i] = tValid; obsD[i] = dOut;
    end
    adcValid = 1'b1;
  endtask

  task automatic scanRuns(input bit useT, input int n);
    logic prev, cur;
    runCount = 0; prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      cur = useT ? obsVT[i] : obsV[i];
      if (cur && !prev && runCount < 8) begin runStart[runCount] = i; runLen[runCount] = 0; runCount++; end
      if (cur && runCount > 0) runLen[runCount-1]++;
      prev = cur;
    end
  endtask

  task automatic test_reset();
    doReset();
    nVec++; if (dValid !== 1'b0) begin nErr++; $display("[TB] FAIL reset_valid got=%0d exp=0", dValid); end
    nVec++; if (dOut !== 16'sd0) begin nErr++; $display("[TB] FAIL reset_data got=%0d exp=0", dOut); end
    nVec++; if (dCount !== 16'd0) begin nErr++; $display("[TB] FAIL reset_count got=%0d exp=0", dCount); end
    nVec++; if ({dTrunc, dGap, dBusy} !== 3'b000) begin nErr++; $display("[TB] FAIL reset_flags got=%b exp=000", {dTrunc, dGap, dBusy}); end
    nVec++; if (dBase !== 16'sd0) begin nErr++; $display("[TB] FAIL reset_baseline got=%0d exp=0", dBase); end
  endtask

  task automatic test_baseline();
    int seen;
    doReset(); loadStim(16'sd1000); baseline = 16'sd1000; seen = 0;
`ifdef BASELINE_TRACK_EN
    runStream(200); runStream(200);
    nVec++; if (dBase < 16'sd999 || dBase > 16'sd1000) begin nErr++; $display("[TB] FAIL track_settle got=%0d exp=999..1000", dBase); end
`endif
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      runStream(200);
      for (int i = 0; i < 200; i++) if (obsV[i]) seen++;
    end
    nVec++; if (seen !== 0) begin nErr++; $display("[TB] FAIL baseline_novalid got=%0d exp=0", seen); end
    nVec++; if (dCount !== 16'd0) begin nErr++; $display("[TB] FAIL baseline_count got=%0d exp=0", dCount); end
`ifndef BASELINE_TRACK_EN
    nVec++; if (dBase !== 16'sd1000) begin nErr++; $display("[TB] FAIL fixed_baseline got=%0d exp=1000", dBase); end
`endif
  endtask

  task automatic test_single_window();
    int bad;
    doReset(); loadStim(16'sd0);
    for (int i = 40; i <= 44; i++) stim[i] = 16'sd500;
    enable = 1'b1; runStream(120); scanRuns(1'b0, 120);
    nVec++; if (runCount !== 1) begin nErr++; $display("[TB] FAIL single_runs got=%0d exp=1", runCount); end
    nVec++; if (runStart[0] !== 41) begin nErr++; $display("[TB] FAIL single_latency got=%0d exp=41", runStart[0]); end
    nVec++; if (runLen[0] !== 29) begin nErr++; $display("[TB] FAIL single_len got=%0d exp=29", runLen[0]); end
    bad = 0;
    for (int n = runStart[0]; n < runStart[0] + runLen[0]; n++) if (obsD[n] !== stim[n-PRE-1]) bad++;
    nVec++; if (bad !== 0) begin nErr++; $display("[TB] FAIL single_data got=%0d bad samples exp=0", bad); end
    nVec++; if (dCount !== 16'd1) begin nErr++; $display("[TB] FAIL single_count got=%0d exp=1", dCount); end
  endtask

  task automatic test_back_to_back();
    int bad;
    doReset(); loadStim(16'sd0);
    for (int i = 40; i <= 44; i++) stim[i] = 16'sd500;
    for (int i = 55; i <= 59; i++) stim[i] = 16'sd500;
    enable = 1'b1; runStream(130); scanRuns(1'b0, 130);
    nVec++; if (runCount !== 1) begin nErr++; $display("[TB] FAIL merge_runs got=%0d exp=1", runCount); end
    nVec++; if (runLen[0] !== 44) begin nErr++; $display("[TB] FAIL merge_len got=%0d exp=44", runLen[0]); end
    bad = 0;
    for (int n = runStart[0]; n < runStart[0] + runLen[0]; n++) if (obsD[n] !== stim[n-PRE-1]) bad++;
    nVec++; if (bad !== 0) begin nErr++; $display("[TB] FAIL merge_data got=%0d bad samples exp=0", bad); end
    nVec++; if (dCount !== 16'd1) begin nErr++; $display("[TB] FAIL merge_count got=%0d exp=1", dCount); end
  endtask

  task automatic test_truncate();
    doReset(); loadStim(16'sd0);
    for (int i = 40; i <= 139; i++) stim[i] = 16'sd500;
    enable = 1'b1; runStream(200);
    scanRuns(1'b1, 200);
    nVec++; if (runCount !== 3) begin nErr++; $display("[TB] FAIL trunc_runs got=%0d exp=3", runCount); end
    nVec++; if (runLen[0] !== 32 || runLen[1] !== 32) begin nErr++; $display("[TB] FAIL trunc_len got=%0d,%0d exp=32,32", runLen[0], runLen[1]); end
    nVec++; if (runStart[1] - runStart[0] - runLen[0] < GAP) begin nErr++; $display("[TB] FAIL trunc_gap got=%0d exp>=%0d", runStart[1] - runStart[0] - runLen[0], GAP); end
    nVec++; if (runLen[2] !== 28) begin nErr++; $display("[TB] FAIL trunc_lastlen got=%0d exp=28", runLen[2]); end
    nVec++; if (tTrunc !== 1'b1) begin nErr++; $display("[TB] FAIL trunc_flag got=%0d exp=1", tTrunc); end
    nVec++; if (tCount !== 16'd3) begin nErr++; $display("[TB] FAIL trunc_count got=%0d exp=3", tCount); end
    scanRuns(1'b0, 200);
    nVec++; if (runCount !== 1 || runLen[0] !== 124) begin nErr++; $display("[TB] FAIL long_len got=%0d runs len=%0d exp=1 runs len=124", runCount, runLen[0]); end
    nVec++; if (dTrunc !== 1'b0) begin nErr++; $display("[TB] FAIL long_trunc got=%0d exp=0", dTrunc); end
  endtask

  task automatic test_gap();
    doReset(); loadStim(16'sd0);
    for (int i = 40; i <= 44; i++) stim[i] = 16'sd500;
    stimV[50] = 1'b0;
    enable = 1'b1; runStream(80);
    nVec++; if ({obsV[49], obsV[50]} !== 2'b10) begin nErr++; $display("[TB] FAIL gap_drop got=%b exp=10", {obsV[49], obsV[50]}); end
    nVec++; if (dGap !== 1'b1) begin nErr++; $display("[TB] FAIL gap_flag got=%0d exp=1", dGap); end
    nVec++; if (dCount !== 16'd1) begin nErr++; $display("[TB] FAIL gap_count got=%0d exp=1", dCount); end
    clear = 1'b1; @(posedge clk); #1 clear = 1'b0;
    nVec++; if (dGap !== 1'b0) begin nErr++; $display("[TB] FAIL gap_clear got=%0d exp=0", dGap); end
  endtask

  task automatic test_reset_mid();
    doReset(); baseline = 16'sd77; loadStim(16'sd77);
    for (int i = 40; i <= 44; i++) stim[i] = 16'sd577;
    enable = 1'b1; runStream(46);
    nVec++; if (obsV[45] !== 1'b1 || dBase !== 16'sd77) begin nErr++; $display("[TB] FAIL midreset_pre got=%0d/%0d exp=1/77", obsV[45], dBase); end
    #2 rst_n = 1'b0;
    #1;
    nVec++; if ({dValid, dCount, dBase} !== 33'd0) begin nErr++; $display("[TB] FAIL midreset_clear got=%0d/%0d/%0d exp=0/0/0", dValid, dCount, dBase); end
    @(posedge clk); #1 rst_n = 1'b1;
    loadStim(16'sd577); runStream(30); scanRuns(1'b0, 30);
    nVec++; if (!(runCount > 0 && runStart[0] >= PRE + 1)) begin nErr++; $display("[TB] FAIL midreset_refill got runs=%0d start=%0d exp start>=%0d", runCount, runStart[0], PRE + 1); end
  endtask

  task automatic test_boundary();
    doReset(); threshold = 16'd500; loadStim(16'sd0);
    for (int i = 40; i <= 44; i++) stim[i] = 16'sd500;
    enable = 1'b1; runStream(80); scanRuns(1'b0, 80);
    nVec++; if (runCount !== 0) begin nErr++; $display("[TB] FAIL equal_threshold got=%0d runs exp=0", runCount); end
    doReset(); baseline = 16'sd1; threshold = 16'd32767; loadStim(16'sd1);
    stim[40] = 16'sh8000;
    enable = 1'b1; runStream(80); scanRuns(1'b0, 80);
    nVec++; if (runCount !== 1 || runLen[0] !== 25) begin nErr++; $display("[TB] FAIL sat_len got runs=%0d len=%0d exp 1/25", runCount, runLen[0]); end
    nVec++; if (obsD[49] !== 16'sh8000) begin nErr++; $display("[TB] FAIL sat_value got=%h exp=8000", obsD[49]); end
  endtask

  initial begin
    test_reset();
    test_baseline();
`ifndef BASELINE_TRACK_EN
    test_single_window();
    test_back_to_back();
    test_truncate();
    test_gap();
    test_reset_mid();
    test_boundary();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout got=stalled exp=finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
